// File: rtl/display_arbiter_if.sv
// Digit/control bundle between the clock controller and the display arbiter.
// The master side supplies time/alarm digits and UI levels; the slave side returns the display word.
interface display_arbiter_if;
  logic [31:0] time_bcd;
  logic [31:0] alarm_bcd;
  logic        view_alarm;
  logic        edit_en;
  logic        edit_src;
  logic [1:0]  edit_field;
  logic        alarm_ring;
  logic [31:0] BCD_out;
  logic [7:0]  blank;
  logic [1:0]  mode;

  modport master (
    output time_bcd, alarm_bcd, view_alarm, edit_en, edit_src, edit_field, alarm_ring,
    input  BCD_out, blank, mode
  );

  modport slave (
    input  time_bcd, alarm_bcd, view_alarm, edit_en, edit_src, edit_field, alarm_ring,
    output BCD_out, blank, mode
  );
endinterface

// File: rtl/display_arbiter.sv
// Chooses which 8-digit BCD word drives the display (time, alarm view, set mode, ringing)
// and generates the blink blanking mask; all outputs registered.
module display_arbiter #(
  parameter int HALF_BLINK  = 25_000_000,
  parameter int VIEW_HALVES = 10
) (
  input logic               clock,
  input logic               reset,
  display_arbiter_if.slave  bus
);

  localparam int CW = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;
  localparam int HW = (VIEW_HALVES > 1) ? $clog2(VIEW_HALVES + 1) : 1;
  localparam logic [CW-1:0] BLINK_LAST  = CW'(HALF_BLINK - 1);
  localparam logic [HW-1:0] HALVES_LAST = HW'(VIEW_HALVES - 1);

  typedef enum logic [1:0] {
    S_TIME = 2'd0,
    S_VIEW = 2'd1,
    S_EDIT = 2'd2,
    S_RING = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] blink_q, blink_d;
  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic [1:0]    field_q;
  logic          src_q;
  logic          wrap, timeout, view_ok, restart, clear;
  logic [31:0]   bcd_d;
  logic [7:0]    blank_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_TIME;
      blink_q     <= '0;
      half_q      <= '0;
      phase_q     <= 1'b0;
      field_q     <= '0;
      src_q       <= 1'b0;
      bus.BCD_out <= '0;
      bus.blank   <= '0;
      bus.mode    <= '0;
    end else begin
      state_q     <= state_d;
      blink_q     <= blink_d;
      half_q      <= half_d;
      phase_q     <= phase_d;
      field_q     <= bus.edit_field;
      src_q       <= bus.edit_src;
      bus.BCD_out <= bcd_d;
      bus.blank   <= blank_d;
      bus.mode    <= state_d;
    end
  end

  // Timeout fires on the wrap that would bring the half count to VIEW_HALVES.
  always_comb begin
    wrap    = (blink_q == BLINK_LAST);
    timeout = (state_q == S_VIEW) && wrap && (half_q == HALVES_LAST);
    view_ok = bus.view_alarm && ((state_q == S_TIME) || (state_q == S_VIEW));
    state_d = state_q;
    if (bus.alarm_ring)
      state_d = S_RING;
    else if (bus.edit_en)
      state_d = S_EDIT;
    else if (view_ok)
      state_d = S_VIEW;
    else if (timeout)
      state_d = S_TIME;
    else if ((state_q == S_RING) || (state_q == S_EDIT))
      state_d = S_TIME;
  end

  always_comb begin
    restart = (state_q == S_VIEW) && (state_d == S_VIEW) && bus.view_alarm;
    clear   = (state_d != state_q) || restart ||
              ((state_q == S_EDIT) && (state_d == S_EDIT) &&
               ((bus.edit_field != field_q) || (bus.edit_src != src_q)));
    blink_d = blink_q + CW'(1);
    half_d  = half_q;
    phase_d = phase_q;
    if (clear) begin
      blink_d = '0;
      half_d  = '0;
      phase_d = 1'b0;
    end else if (wrap) begin
      blink_d = '0;
      phase_d = ~phase_q;
      if (state_q == S_VIEW)
        half_d = half_q + HW'(1);
    end
  end

  // Output word follows the next state and next phase so it lands with mode.
  always_comb begin
    bcd_d   = bus.time_bcd;
    blank_d = '0;
    case (state_d)
      S_VIEW: bcd_d = bus.alarm_bcd;
      S_EDIT: begin
        bcd_d = bus.edit_src ? bus.alarm_bcd : bus.time_bcd;
        if (phase_d)
          blank_d = 8'h03 << {bus.edit_field, 1'b0};
      end
      S_RING: begin
        if (phase_d)
          blank_d = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HALF_BLINK=4, VIEW_HALVES=3.
module tb_display_arbiter;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  display_arbiter_if bus();

  display_arbiter #(.HALF_BLINK(4), .VIEW_HALVES(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] time_v;
    logic [31:0] alarm_v;
    logic        view;
    logic        edit;
    logic        src;
    logic [1:0]  field;
    logic        ring;
    logic [31:0] exp_bcd;
    logic [7:0]  exp_blank;
    logic [1:0]  exp_mode;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string name, input logic [31:0] bcd, input logic [7:0] blk,
                           input logic [1:0] md);
    check({name, ".bcd"}, bus.BCD_out, bcd);
    check({name, ".blank"}, {24'h0, bus.blank}, {24'h0, blk});
    check({name, ".mode"}, {30'h0, bus.mode}, {30'h0, md});
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    //          time          alarm         vw ed sr fl rg  exp_bcd       blk    mode
    vecs[0]  = '{32'h00123456, 32'h00070000, 0, 0, 0, 0, 0, 32'h00123456, 8'h00, 2'd0};
    vecs[1]  = '{32'h12345678, 32'h00070000, 0, 0, 0, 0, 0, 32'h12345678, 8'h00, 2'd0};
    vecs[2]  = '{32'h12345678, 32'h00070000, 0, 0, 0, 0, 1, 32'h12345678, 8'h00, 2'd3};
    vecs[3]  = '{32'h12345678, 32'h00070000, 1, 0, 0, 0, 1, 32'h12345678, 8'h00, 2'd3};
    vecs[4]  = '{32'h12345678, 32'h00070000, 0, 1, 1, 0, 0, 32'h00070000, 8'h00, 2'd2};
    vecs[5]  = '{32'h12345678, 32'h00070000, 0, 1, 0, 0, 0, 32'h12345678, 8'h00, 2'd2};
    vecs[6]  = '{32'h12345678, 32'h00070000, 1, 0, 0, 0, 0, 32'h12345678, 8'h00, 2'd0};
    vecs[7]  = '{32'h12345678, 32'h00070000, 1, 0, 0, 0, 0, 32'h00070000, 8'h00, 2'd1};
    vecs[8]  = '{32'h12345678, 32'h99999999, 0, 0, 0, 0, 0, 32'h99999999, 8'h00, 2'd1};
    vecs[9]  = '{32'h12345678, 32'h99999999, 1, 0, 0, 0, 1, 32'h12345678, 8'h00, 2'd3};
    vecs[10] = '{32'h12345678, 32'h99999999, 0, 0, 0, 0, 0, 32'h12345678, 8'h00, 2'd0};
    vecs[11] = '{32'h12345678, 32'h99999999, 0, 1, 0, 0, 1, 32'h12345678, 8'h00, 2'd3};
    vecs[12] = '{32'h12345678, 32'h99999999, 0, 1, 0, 0, 0, 32'h12345678, 8'h00, 2'd2};
    vecs[13] = '{32'h12345678, 32'h99999999, 0, 0, 0, 0, 0, 32'h12345678, 8'h00, 2'd0};

    reset          = 1'b1;
    bus.time_bcd   = 32'h00123456;
    bus.alarm_bcd  = 32'h00070000;
    bus.view_alarm = 1'b0;
    bus.edit_en    = 1'b0;
    bus.edit_src   = 1'b0;
    bus.edit_field = 2'd0;
    bus.alarm_ring = 1'b0;
    tick();
    tick();
    check_out("reset_hold", 32'h0, 8'h00, 2'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      bus.time_bcd   = vecs[i].time_v;
      bus.alarm_bcd  = vecs[i].alarm_v;
      bus.view_alarm = vecs[i].view;
      bus.edit_en    = vecs[i].edit;
      bus.edit_src   = vecs[i].src;
      bus.edit_field = vecs[i].field;
      bus.alarm_ring = vecs[i].ring;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].exp_bcd, vecs[i].exp_blank, vecs[i].exp_mode);
    end
    bus.view_alarm = 1'b0;

    // Single view pulse: 12 cycles of VIEW.
    bus.alarm_bcd  = 32'h00070000;
    bus.view_alarm = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      tick();
      bus.view_alarm = 1'b0;
      check($sformatf("view1_mode_k%0d", k), {30'h0, bus.mode}, (k < 12) ? 32'd1 : 32'd0);
      check($sformatf("view1_bcd_k%0d", k), bus.BCD_out, (k < 12) ? 32'h00070000 : 32'h12345678);
    end

    // Second pulse at cycle 8 extends VIEW to 20 cycles.
    bus.view_alarm = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      bus.view_alarm = (k == 7);
      check($sformatf("view2_mode_k%0d", k), {30'h0, bus.mode}, (k < 20) ? 32'd1 : 32'd0);
    end

    // Set mode blink on field 1, then field 2 restarts the blink.
    bus.edit_en    = 1'b1;
    bus.edit_src   = 1'b1;
    bus.edit_field = 2'd1;
    for (int k = 0; k < 14; k++) begin
      tick();
      check_out($sformatf("edit_f1_k%0d", k), 32'h00070000, ((k / 4) % 2 == 1) ? 8'h0C : 8'h00, 2'd2);
    end
    bus.edit_field = 2'd2;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out($sformatf("edit_f2_k%0d", k), 32'h00070000, ((k / 4) % 2 == 1) ? 8'h30 : 8'h00, 2'd2);
    end

    // Ring over edit, then drop ring while still editing.
    bus.alarm_ring = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_out($sformatf("ring_k%0d", k), 32'h12345678, ((k / 4) % 2 == 1) ? 8'hFF : 8'h00, 2'd3);
    end
    bus.alarm_ring = 1'b0;
    tick();
    check_out("ring_to_edit", 32'h00070000, 8'h00, 2'd2);
    bus.edit_en = 1'b0;
    tick();
    check_out("edit_to_time", 32'h12345678, 8'h00, 2'd0);

    // View request while ringing is dropped.
    bus.alarm_ring = 1'b1;
    tick();
    check_out("ring2_enter", 32'h12345678, 8'h00, 2'd3);
    bus.view_alarm = 1'b1;
    tick();
    check_out("ring2_view", 32'h12345678, 8'h00, 2'd3);
    bus.view_alarm = 1'b0;
    tick();
    check_out("ring2_hold", 32'h12345678, 8'h00, 2'd3);
    bus.alarm_ring = 1'b0;
    tick();
    check_out("ring2_exit", 32'h12345678, 8'h00, 2'd0);
    tick();
    check_out("ring2_after", 32'h12345678, 8'h00, 2'd0);

    // Asynchronous reset mid-RING, between edges.
    bus.alarm_ring = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check_out("ring3_hidden", 32'h12345678, 8'hFF, 2'd3);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 32'h0, 8'h00, 2'd0);
    bus.alarm_ring = 1'b0;
    bus.time_bcd   = 32'h00987654;
    #1;
    reset = 1'b0;
    tick();
    check_out("post_reset", 32'h00987654, 8'h00, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HALF_BLINK, default 25_000_000: clock cycles per blink half-period.
REQ-002 Parameter VIEW_HALVES, default 10: number of blink half-periods the alarm view is held.
REQ-003 clock  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 time_bcd  input  32  current time, 8 BCD digits; [3:0] is the rightmost digit.
REQ-006 alarm_bcd  input  32  alarm setpoint, 8 BCD digits, same packing as time_bcd.
REQ-007 view_alarm  input  1  single-cycle request to show alarm_bcd temporarily.
REQ-008 edit_en  input  1  level; set mode is active.
REQ-009 edit_src  input  1  source shown in set mode: 0 = time, 1 = alarm.
REQ-010 edit_field  input  2  digit pair being edited: 0 = digits [7:0], 1 = [15:8], 2 = [23:16], 3 = [31:24].
REQ-011 alarm_ring  input  1  level; alarm is sounding.
REQ-012 BCD_out  output  32  registered digit word to the display multiplexer.
REQ-013 blank  output  8  registered; bit i = 1 turns off digit i (bit 0 = rightmost).
REQ-014 mode  output  2  registered current state: 0 TIME, 1 VIEW, 2 EDIT, 3 RING.

Function
REQ-015 States are TIME, VIEW, EDIT and RING, with priority RING > EDIT > VIEW > TIME, evaluated every cycle.
REQ-016 Transitions:
  - alarm_ring=1 -> RING from any state.
  - Else edit_en=1 -> EDIT.
  - Else view_alarm=1 in TIME or VIEW -> VIEW.
  - Else VIEW timeout expired -> TIME.
  - RING or EDIT with its level input deasserted -> TIME.
REQ-017 view_alarm in EDIT or RING is ignored, not queued.
REQ-018 view_alarm while in VIEW restarts the view timeout.
REQ-019 A blink counter counts 0..HALF_BLINK-1 and wraps; on each wrap the blink phase toggles (0 = visible, 1 = hidden).
REQ-020 Counter and phase clear to 0 on any state change, and on an edit_field or edit_src change while in EDIT.
REQ-021 VIEW timeout: a half-period counter increments on each blink wrap in VIEW; the exit to TIME occurs on the cycle the count reaches VIEW_HALVES, i.e. VIEW lasts VIEW_HALVES*HALF_BLINK cycles.
REQ-022 Per-state outputs:
  - TIME: BCD_out = time_bcd, blank = 8'h00.
  - VIEW: BCD_out = alarm_bcd, blank = 8'h00.
  - EDIT: BCD_out = time_bcd or alarm_bcd per edit_src; blank = pair mask for edit_field (8'h03 << 2*edit_field) when phase = 1, else 8'h00.
  - RING: BCD_out = time_bcd; blank = 8'hFF when phase = 1, else 8'h00.
REQ-023 BCD_out, blank and mode are registered and reflect the next-state decision one cycle after the input sample; BCD_out tracks input digit changes with 1-cycle latency in every state.
REQ-024 Input BCD values are passed through unchecked; no arithmetic is performed on digit data.
REQ-025 Simultaneous view_alarm and alarm_ring: enter RING; the view request is dropped.
REQ-026 alarm_ring deasserting while edit_en=1: enter EDIT with phase cleared.

Reset
REQ-027 While reset=1: state = TIME, BCD_out = 32'h0, blank = 8'h00, mode = 0, all counters and blink phase = 0.
REQ-028 After reset release, the first rising edge loads BCD_out = time_bcd.
REQ-029 A reset asserted mid-VIEW, mid-EDIT or mid-RING takes effect immediately and is not held off by the clock.

Verification (HALF_BLINK=4, VIEW_HALVES=3)
REQ-030 Reset release, time_bcd=32'h00123456 -> after 1 edge, BCD_out=32'h00123456, blank=00, mode=0.
REQ-031 view_alarm pulse, alarm_bcd=32'h00070000 -> BCD_out=32'h00070000 and mode=1 for exactly 12 cycles, then TIME; a second pulse at cycle 8 extends VIEW to 20 cycles total.
REQ-032 edit_en=1, edit_src=1, edit_field=1 -> blank alternates 00 / 0C every 4 cycles, starting with 00; changing edit_field to 2 restarts at 00, then 30.
REQ-033 alarm_ring=1 during EDIT -> mode=3, blank alternates 00 / FF every 4 cycles; alarm_ring=0 with edit_en=1 -> mode=2, phase visible.
REQ-034 view_alarm pulse in RING -> no effect; after alarm_ring=0 and edit_en=0 -> mode=0, not 1.
REQ-035 reset asserted mid-RING between clock edges -> outputs at reset values immediately, before the next edge.
